// File: rtl/alu_pkg.sv
// Shared encodings for the slice-serial ALU: operation codes and FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SLT = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    SETLESS = 2'b10,
    DONE    = 2'b11
  } state_t;

endpackage

// File: rtl/alu_multicycle_slice.sv
// One SLICE-bit ALU slice: AND/OR/ADD with optional b inversion, plus the
// carry into the MSB so the caller can form signed overflow.
module alu_slice
  import alu_pkg::*;
#(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             binv,
  input  logic             cin,
  input  op_t              op,
  output logic [SLICE-1:0] y,
  output logic             cout,
  output logic             cmsb
);

  logic [SLICE-1:0] bb;
  logic [SLICE:0]   sum;

  // Slice function; SLT passes the adder sum so the MSB is available later.
  always_comb begin
    bb   = binv ? ~b : b;
    sum  = {1'b0, a} + {1'b0, bb} + (SLICE+1)'(cin);
    cout = sum[SLICE];
    // Carry into the MSB recovered from the MSB sum bit and its operands.
    cmsb = sum[SLICE-1] ^ a[SLICE-1] ^ bb[SLICE-1];
    case (op)
      OP_AND:  y = a & bb;
      OP_OR:   y = a | bb;
      default: y = sum[SLICE-1:0];
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Slice-serial ALU: one SLICE-bit slice reused over WIDTH/SLICE cycles with a
// registered inter-slice carry, start/done handshake, full-word SLT and flags.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [1:0]       op,
  input  logic             binv,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             zero,
  output logic             ovf,
  output logic             done
);

  localparam int unsigned N     = WIDTH / SLICE;
  localparam int unsigned KW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] KLAST = KW'(N - 1);

  generate
    if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_param_check
      $error("alu_multicycle: WIDTH must be a non-zero multiple of SLICE");
    end
  endgenerate

  state_t           state;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  op_t              op_r;
  logic             binv_r;
  logic             v_r;

  logic [IW-1:0]    base;
  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic [SLICE-1:0] y;
  logic             cout;
  logic             cmsb;
  logic [WIDTH-1:0] res_wr;
  logic             start_slt;

  // Select the current slice operands and form the result with it merged in.
  always_comb begin
    base      = IW'(32'(k) * SLICE);
    sa        = a_r[base +: SLICE];
    sb        = b_r[base +: SLICE];
    res_wr    = result;
    res_wr[base +: SLICE] = y;
    start_slt = (op_t'(op) == OP_SLT);
  end

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a    (sa),
    .b    (sb),
    .binv (binv_r),
    .cin  (carry),
    .op   (op_r),
    .y    (y),
    .cout (cout),
    .cmsb (cmsb)
  );

  // Control FSM with operand latches, slice counter, carry and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      k      <= '0;
      carry  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= OP_AND;
      binv_r <= 1'b0;
      v_r    <= 1'b0;
      result <= '0;
      co     <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
      done   <= 1'b0;
      ready  <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            op_r   <= op_t'(op);
            binv_r <= start_slt | binv;
            carry  <= start_slt | cin;
            k      <= '0;
            ready  <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          result <= res_wr;
          carry  <= cout;
          if (k == KLAST) begin
            co  <= cout;
            v_r <= cmsb ^ cout;
            ovf <= (op_r == OP_ADD) & (cmsb ^ cout);
            if (op_r == OP_SLT) begin
              state <= SETLESS;
            end else begin
              zero  <= (res_wr == '0);
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            k <= k + KW'(1);
          end
        end
        SETLESS: begin
          // Signed less-than: adder sign corrected by overflow.
          result <= WIDTH'(result[WIDTH-1] ^ v_r);
          zero   <= ~(result[WIDTH-1] ^ v_r);
          ovf    <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: a 32/8 and a 16/4 instance driven
// with directed and random operations, checked against a word-level model.
module tb_alu_multicycle;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rstv  [2];
  logic        st    [2];
  logic [1:0]  opv   [2];
  logic        binvv [2];
  logic        cinv  [2];
  logic [31:0] av    [2];
  logic [31:0] bv    [2];
  logic        rdyv  [2];
  logic        cov   [2];
  logic        zv    [2];
  logic        vv    [2];
  logic        dnv   [2];
  logic [31:0] r32;
  logic [15:0] r16;
  logic [31:0] resv  [2];

  assign resv[0] = r32;
  assign resv[1] = {16'h0, r16};

  alu_multicycle #(.WIDTH(32), .SLICE(8)) u32 (
    .clk(clk), .rst(rstv[0]), .start(st[0]), .ready(rdyv[0]), .op(opv[0]),
    .binv(binvv[0]), .cin(cinv[0]), .a(av[0]), .b(bv[0]), .result(r32),
    .co(cov[0]), .zero(zv[0]), .ovf(vv[0]), .done(dnv[0])
  );

  alu_multicycle #(.WIDTH(16), .SLICE(4)) u16 (
    .clk(clk), .rst(rstv[1]), .start(st[1]), .ready(rdyv[1]), .op(opv[1]),
    .binv(binvv[1]), .cin(cinv[1]), .a(av[1][15:0]), .b(bv[1][15:0]), .result(r16),
    .co(cov[1]), .zero(zv[1]), .ovf(vv[1]), .done(dnv[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expectations for the operation in flight on each instance.
  bit          pend      [2];
  logic [31:0] exp_res   [2];
  logic        exp_co    [2];
  logic        exp_zero  [2];
  logic        exp_ovf   [2];
  int          exp_cyc   [2];
  int          issue_c   [2];
  int          done_cnt  [2];
  int          last_done [2];

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[dut%0d]: got %h expected %h", name, i, act, exp);
    end
  endtask

  function automatic longint sext(input longint unsigned x, input int w);
    if (((x >> (w - 1)) & 64'd1) != 0) return longint'(x) - (longint'(1) << w);
    return longint'(x);
  endfunction

  // Word-level reference: plain arithmetic on the full operands.
  function automatic void model(input int w, input logic [1:0] op, input logic binv_i,
                                input logic cin_i, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic co, output logic z,
                                output logic v);
    longint unsigned mask, ua, ub, bb, sum;
    longint ssum, smax, smin;
    logic bi, ci;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'h0, a} & mask;
    ub   = {32'h0, b} & mask;
    bi   = (op == 2'b11) ? 1'b1 : binv_i;
    ci   = (op == 2'b11) ? 1'b1 : cin_i;
    bb   = bi ? (~ub & mask) : ub;
    sum  = ua + bb + {63'h0, ci};
    co   = ((sum >> w) & 64'd1) != 0;
    ssum = sext(ua, w) + sext(bb, w) + longint'(ci);
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    v    = 1'b0;
    case (op)
      2'b00:   r = 32'(ua & bb);
      2'b01:   r = 32'(ua | bb);
      2'b10: begin
        r = 32'(sum & mask);
        v = (ssum > smax) || (ssum < smin);
      end
      default: r = (sext(ua, w) < sext(ub, w)) ? 32'd1 : 32'd0;
    endcase
    z = (r == 32'd0);
  endfunction

  // Per-cycle check: ready tracks idleness, done only when expected and on time.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("ready", i, 32'(rdyv[i]), 32'(!pend[i]));
      if (dnv[i]) begin
        done_cnt[i]  = done_cnt[i] + 1;
        last_done[i] = cyc;
        if (!pend[i]) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done[dut%0d]: got done=1 expected done=0", i);
        end else begin
          chk("done_cycle", i, 32'(cyc), 32'(exp_cyc[i]));
          chk("result", i, resv[i], exp_res[i]);
          chk("co", i, 32'(cov[i]), 32'(exp_co[i]));
          chk("zero", i, 32'(zv[i]), 32'(exp_zero[i]));
          chk("ovf", i, 32'(vv[i]), 32'(exp_ovf[i]));
        end
      end
    end
  end

  // Issue one operation and wait for its done; optional start pulses while busy.
  task automatic issue(input int i, input logic [1:0] op, input logic binv, input logic cin,
                       input logic [31:0] a, input logic [31:0] b, input bit disturb);
    int dc0;
    for (int t = 0; t < 20 && !rdyv[i]; t++) begin @(negedge clk); #1; end
    if (!rdyv[i]) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout[dut%0d]: got ready=0 expected ready=1", i);
      return;
    end
    model((i == 0) ? 32 : 16, op, binv, cin, a, b, exp_res[i], exp_co[i], exp_zero[i], exp_ovf[i]);
    issue_c[i] = cyc;
    exp_cyc[i] = cyc + 1 + N + ((op == 2'b11) ? 1 : 0);
    dc0 = done_cnt[i];
    opv[i] = op; binvv[i] = binv; cinv[i] = cin; av[i] = a; bv[i] = b;
    st[i] = 1'b1;
    pend[i] = 1'b1;
    @(negedge clk); #1;
    st[i] = 1'b0;
    opv[i] = 2'($urandom); av[i] = $urandom; bv[i] = $urandom;
    binvv[i] = 1'($urandom); cinv[i] = 1'($urandom);
    if (disturb) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clk); #1;
        st[i] = 1'b1;
        opv[i] = 2'($urandom); av[i] = $urandom; bv[i] = $urandom;
      end
      @(negedge clk); #1;
      st[i] = 1'b0;
    end
    for (int t = 0; t < N + 10 && done_cnt[i] == dc0; t++) begin @(negedge clk); #1; end
    if (done_cnt[i] == dc0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout[dut%0d]: got no done expected done", i);
    end
    pend[i] = 1'b0;
  endtask

  // Directed case with hand-computed literal expectations and latency.
  task automatic directed(input int i, input logic [1:0] op, input logic binv, input logic cin,
                          input logic [31:0] a, input logic [31:0] b, input bit disturb,
                          input logic [31:0] xr, input logic xz, input logic xc,
                          input logic xv, input int lat);
    issue(i, op, binv, cin, a, b, disturb);
    chk("lit_result", i, resv[i], xr);
    chk("lit_zero", i, 32'(zv[i]), 32'(xz));
    chk("lit_co", i, 32'(cov[i]), 32'(xc));
    chk("lit_ovf", i, 32'(vv[i]), 32'(xv));
    chk("lit_latency", i, 32'(last_done[i] - issue_c[i]), 32'(lat));
  endtask

  // Reset asserted in cycle 3 of an ADD: outputs clear at once, no done follows.
  task automatic mid_reset(input int i);
    for (int t = 0; t < 20 && !rdyv[i]; t++) begin @(negedge clk); #1; end
    opv[i] = 2'b10; binvv[i] = 1'b0; cinv[i] = 1'b0;
    av[i] = 32'hFFFF_FFFF; bv[i] = 32'h0000_0003;
    st[i] = 1'b1;
    pend[i] = 1'b1;
    @(negedge clk); #1; st[i] = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    rstv[i] = 1'b1;
    pend[i] = 1'b0;
    #1;
    chk("rst_result", i, resv[i], 32'h0);
    chk("rst_co", i, 32'(cov[i]), 32'h0);
    chk("rst_zero", i, 32'(zv[i]), 32'h0);
    chk("rst_ovf", i, 32'(vv[i]), 32'h0);
    chk("rst_done", i, 32'(dnv[i]), 32'h0);
    chk("rst_ready", i, 32'(rdyv[i]), 32'h1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    rstv[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rstv[i] = 1'b1; st[i] = 1'b0; opv[i] = 2'b00; binvv[i] = 1'b0; cinv[i] = 1'b0;
      av[i] = '0; bv[i] = '0; pend[i] = 1'b0; done_cnt[i] = 0; last_done[i] = 0;
    end
    @(negedge clk); #1;
    @(negedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk("init_result", i, resv[i], 32'h0);
      chk("init_flags", i, {29'h0, cov[i], zv[i], vv[i]}, 32'h0);
      chk("init_done", i, 32'(dnv[i]), 32'h0);
      rstv[i] = 1'b0;
    end
    @(negedge clk); #1;

    directed(0, 2'b10, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 5);
    directed(0, 2'b10, 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 5);
    directed(0, 2'b10, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 5);
    directed(0, 2'b11, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 6);
    directed(0, 2'b11, 1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 6);
    directed(0, 2'b11, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 6);
    directed(0, 2'b00, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000, 1'b0, 1'b1, 1'b0, 5);
    directed(0, 2'b01, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hFFF0_FFF0, 1'b0, 1'b1, 1'b0, 5);
    directed(0, 2'b11, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 6);
    directed(1, 2'b10, 1'b0, 1'b0, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 32'h0000_8000, 1'b0, 1'b0, 1'b1, 5);
    directed(1, 2'b11, 1'b0, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 6);
    directed(1, 2'b10, 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 5);

    for (int i = 0; i < 2; i++) begin
      mid_reset(i);
      directed(i, 2'b10, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 5);
    end

    for (int n = 0; n < 60; n++) begin
      int i;
      logic [31:0] ra, rb;
      i  = n % 2;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000 >> ((i == 0) ? 0 : 16);
        1: rb = ra;
        2: ra = 32'hFFFF_FFFF;
        default: ;
      endcase
      issue(i, 2'($urandom), 1'($urandom), 1'($urandom), ra, rb, ($urandom_range(0, 3) == 0));
    end

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
